comp_test_sequencer: RTL and testbench

Digital controller that sequences comparator characterization runs. The flow is: DC offset search, then PRBS settle, then a timed PRBS error-count window, then a result report.
- Drives the enables for the offset-search monitor and the PRBS7 generator/checker.
- Aggregates the checker and timing-monitor status into a sticky fail bitmask and an error count.
- Sits beside the characterizer, generator and checker, on the same clock as the comparator.

---
 rtl/comp_seq_pkg.sv | 27 ++
 rtl/comp_test_sequencer_sync_2ff.sv | 26 ++
 rtl/comp_test_sequencer.sv | 158 +++++++++++++++
 tb/tb_comp_test_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/comp_seq_pkg.sv
// Shared types and constants for the comparator characterization sequencer.
package comp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    SETTLE,
    PRBS,
    REPORT,
    DONE
  } state_t;

  localparam int unsigned FAIL_W       = 5;
  localparam int unsigned FAIL_TIMEOUT = 0;
  localparam int unsigned FAIL_PRBS    = 1;
  localparam int unsigned FAIL_SETUP   = 2;
  localparam int unsigned FAIL_HOLD    = 3;
  localparam int unsigned FAIL_LOST    = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/comp_test_sequencer_sync_2ff.sv
// Two-flop synchronizer bank for asynchronous status flags, reset to 0.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/comp_test_sequencer.sv
// Sequences offset search, PRBS settle and a timed PRBS error window, then reports results.
module comp_test_sequencer
  import comp_seq_pkg::*;
#(
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned SETTLE_CYC     = 16,
  parameter int unsigned PRBS_CYC       = 250,
  parameter int unsigned ERR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              search_done,
  input  logic              prbs_err,
  input  logic              setup_viol,
  input  logic              hold_viol,
  output logic              search_en,
  output logic              prbs_en,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FAIL_W-1:0] fail_mask,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned CNT_MAX = max3(SEARCH_TIMEOUT, SETTLE_CYC, PRBS_CYC);
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] SEARCH_LAST = CW'(SEARCH_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] PRBS_LAST   = CW'(PRBS_CYC - 1);

  logic [3:0] sync_s;
  logic       sdone_s;
  logic       perr_s;
  logic       setup_s;
  logic       hold_s;

  sync_2ff #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({hold_viol, setup_viol, prbs_err, search_done}),
    .q_o (sync_s)
  );

  assign sdone_s = sync_s[0];
  assign perr_s  = sync_s[1];
  assign setup_s = sync_s[2];
  assign hold_s  = sync_s[3];

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              search_en_q, search_en_d;
  logic              prbs_en_q, prbs_en_d;
  logic              pass_q, pass_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fail_q      <= '0;
      err_q       <= '0;
      search_en_q <= 1'b0;
      prbs_en_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
      search_en_q <= search_en_d;
      prbs_en_q   <= prbs_en_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    fail_d  = fail_q;
    err_d   = err_q;

    case (state_q)
      IDLE, DONE: begin
        cnt_d = '0;
        if (start) begin
          state_d = SEARCH;
          fail_d  = '0;
          err_d   = '0;
        end
      end
      SEARCH: begin
        if (sdone_s) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == SEARCH_LAST) begin
          state_d              = REPORT;
          fail_d[FAIL_TIMEOUT] = 1'b1;
        end
      end
      SETTLE: begin
        if (!sdone_s) begin
          state_d           = REPORT;
          fail_d[FAIL_LOST] = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = PRBS;
          cnt_d   = '0;
        end
      end
      PRBS: begin
        // Status from this cycle is folded in even when the window is cut short.
        if (perr_s) begin
          fail_d[FAIL_PRBS] = 1'b1;
          if (err_q != '1) err_d = err_q + ERR_W'(1);
        end
        if (setup_s) fail_d[FAIL_SETUP] = 1'b1;
        if (hold_s)  fail_d[FAIL_HOLD]  = 1'b1;
        if (!sdone_s) begin
          state_d           = REPORT;
          fail_d[FAIL_LOST] = 1'b1;
        end else if (cnt_q == PRBS_LAST) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        state_d = DONE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      fail_d  = '0;
      err_d   = '0;
    end

    search_en_d = (state_d == SEARCH) || (state_d == SETTLE) || (state_d == PRBS);
    prbs_en_d   = (state_d == SETTLE) || (state_d == PRBS);
    pass_d      = (state_d == DONE) && (fail_d == '0);
  end

  assign search_en = search_en_q;
  assign prbs_en   = prbs_en_q;
  assign pass      = pass_q;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign fail_mask = fail_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_comp_test_sequencer.sv
// Directed scoreboard bench for comp_test_sequencer (short timeout, 4-bit error counter).
module tb_comp_test_sequencer;

  localparam int unsigned TO    = 64;
  localparam int unsigned EW    = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic          search_done, prbs_err, setup_viol, hold_viol;
  logic          search_en, prbs_en, busy, done, pass;
  logic [4:0]    fail_mask;
  logic [EW-1:0] err_count;

  typedef struct {
    logic [4:0]    fm;
    logic [EW-1:0] ec;
    logic          ps;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  comp_test_sequencer #(
    .SEARCH_TIMEOUT (TO),
    .SETTLE_CYC     (16),
    .PRBS_CYC       (250),
    .ERR_W          (EW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .search_done (search_done),
    .prbs_err    (prbs_err),
    .setup_viol  (setup_viol),
    .hold_viol   (hold_viol),
    .search_en   (search_en),
    .prbs_en     (prbs_en),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_mask   (fail_mask),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [4:0] fm, input logic [EW-1:0] ec, input logic ps);
    exp_t e;
    e.fm = fm;
    e.ec = ec;
    e.ps = ps;
    sb.push_back(e);
  endtask

  // Leaves the bench at the edge where SETTLE is entered (t = 0).
  task automatic begin_run(input string tag);
    search_done = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_search_en"}, search_en, 1);
    repeat (5) tick();
    search_done = 1'b1;
    tick();
    tick();
    chk({tag, "_prbs_en_lag"}, prbs_en, 0);
    tick();
    chk({tag, "_prbs_en"}, prbs_en, 1);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done, 1);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_fail_mask"}, fail_mask, e.fm);
      chk({tag, "_err_count"}, err_count, e.ec);
      chk({tag, "_pass"}, pass, e.ps);
    end
    search_done = 1'b0;
    prbs_err    = 1'b0;
  endtask

  initial begin
    logic seen_prbs;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    search_done = 1'b0; prbs_err = 1'b0; setup_viol = 1'b0; hold_viol = 1'b0;
    repeat (3) tick();
    chk("rst_outputs", {search_en, prbs_en, busy, done, pass, fail_mask, err_count}, 0);
    rst = 1'b0;
    tick();

    // 1: clean run, start mid-run ignored, exact window length
    push(5'b00000, 0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_search_en", search_en, 1);
    chk("t1_prbs_en_idle", prbs_en, 0);
    repeat (39) tick();
    search_done = 1'b1;
    tick();
    tick();
    chk("t1_prbs_en_lag", prbs_en, 0);
    tick();
    chk("t1_prbs_en", prbs_en, 1);
    chk("t1_search_hold", search_en, 1);
    repeat (100) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (164) tick();
    chk("t1_last_prbs", {prbs_en, done}, 2'b10);
    tick();
    chk("t1_report", {busy, search_en, prbs_en, done}, 4'b1000);
    tick();
    chk("t1_done_now", done, 1);
    wait_done("t1");

    // 2: errors in SETTLE ignored, 3 in PRBS counted
    push(5'b00010, 3, 1'b0);
    begin_run("t2");
    tick();
    prbs_err = 1'b1;
    repeat (5) tick();
    prbs_err = 1'b0;
    repeat (94) tick();
    prbs_err = 1'b1;
    repeat (3) tick();
    prbs_err = 1'b0;
    wait_done("t2");

    // 3: timeout after exactly TO search cycles
    push(5'b00001, 0, 1'b0);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    seen_prbs = 1'b0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (prbs_en === 1'b1) seen_prbs = 1'b1;
    end
    chk("t3_still_search", search_en, 1);
    tick();
    chk("t3_report", {busy, search_en, done}, 3'b100);
    chk("t3_no_prbs", seen_prbs, 0);
    wait_done("t3");

    // 4: setup and hold violations
    push(5'b01100, 0, 1'b0);
    begin_run("t4");
    repeat (120) tick();
    setup_viol = 1'b1;
    tick();
    setup_viol = 1'b0;
    repeat (30) tick();
    hold_viol = 1'b1;
    tick();
    hold_viol = 1'b0;
    wait_done("t4");

    // 5: abort beats start mid-PRBS, then a fresh run
    begin_run("t5");
    repeat (100) tick();
    prbs_err = 1'b1;
    tick();
    tick();
    prbs_err = 1'b0;
    repeat (5) tick();
    chk("t5_pre_abort_ec", err_count, 2);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("t5_abort_outputs", {search_en, prbs_en, busy, done, pass, fail_mask, err_count}, 0);
    search_done = 1'b0;
    tick();
    chk("t5_stays_idle", busy, 0);
    push(5'b00000, 0, 1'b1);
    begin_run("t5b");
    wait_done("t5b");

    // 6a: search_done lost in PRBS cycle 100
    push(5'b10000, 0, 1'b0);
    begin_run("t6a");
    repeat (115) tick();
    search_done = 1'b0;
    tick();
    tick();
    chk("t6a_still_prbs", {busy, prbs_en}, 2'b11);
    tick();
    chk("t6a_report", {busy, search_en, prbs_en, done}, 4'b1000);
    tick();
    chk("t6a_done_next", done, 1);
    wait_done("t6a");

    // 6b: error every window cycle saturates the counter
    push(5'b00010, 4'hF, 1'b0);
    begin_run("t6b");
    repeat (14) tick();
    prbs_err = 1'b1;
    wait_done("t6b");

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
